iwm_soft_switches: RTL and testbench

- Downstream consumer of the card's slot-address decode: interprets Apple II accesses to the card's 16-byte device-select space ($C0n0–$C0nF) as IWM soft-switch toggles.
- Holds the stepper phase, motor, drive-select and Q6/Q7 state, plus the IWM mode register.
- Applies the IWM motor-off delay timer; its outputs feed the drive interface and the read/write data path.

---
 rtl/iwm_soft_switches.sv | 123 ++++++++++++
 tb/tb_iwm_soft_switches.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/iwm_soft_switches.sv
// IWM soft-switch block: decodes device-select accesses into phase/motor/drive/Q6/Q7
// toggles, holds the IWM mode register and runs the motor-off delay timer.
module iwm_soft_switches #(
  parameter int MOTOR_DELAY = 7159090,
  parameter int CNT_W       = 24
) (
  input  logic       fclk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic       _devsel,
  input  logic       rw,
  input  logic [7:0] data,
  output logic [3:0] phase,
  output logic       motorOn,
  output logic       motorActive,
  output logic       driveSel,
  output logic       q6,
  output logic       q7,
  output logic [4:0] modeReg,
  output logic       accessStrobe
);

  logic             sync1_q, sync2_q, hist_q;
  logic [3:0]       phase_q, phase_d;
  logic             motor_on_q, motor_on_d;
  logic             motor_active_q, motor_active_d;
  logic             drive_sel_q, drive_sel_d;
  logic             q6_q, q6_d;
  logic             q7_q, q7_d;
  logic [4:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_evt, rise_evt;
  logic             unused_data;

  assign unused_data = ^data[7:5];

  // _devsel is asynchronous to fclk; edges are detected only after synchronization
  always_ff @(posedge fclk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= _devsel;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign fall_evt = ~sync2_q & hist_q;
  assign rise_evt = sync2_q & ~hist_q;

  always_comb begin
    phase_d        = phase_q;
    motor_on_d     = motor_on_q;
    motor_active_d = motor_active_q;
    drive_sel_d    = drive_sel_q;
    q6_d           = q6_q;
    q7_d           = q7_q;
    mode_d         = mode_q;
    cnt_d          = cnt_q;

    if (fall_evt) begin
      case (addr[3:1])
        3'd0, 3'd1, 3'd2, 3'd3: phase_d[addr[2:1]] = addr[0];
        3'd4:                   motor_on_d         = addr[0];
        3'd5:                   drive_sel_d        = addr[0];
        3'd6:                   q6_d               = addr[0];
        default:                q7_d               = addr[0];
      endcase
    end

    if (rise_evt && !rw && addr[0] && q6_q && q7_q && !motor_on_q)
      mode_d = data[4:0];

    // Motor-on cancels any countdown; a motor-off retriggers only on a real 1->0 transition
    if (!motor_on_q && motor_on_d) begin
      motor_active_d = 1'b1;
      cnt_d          = '0;
    end else if (motor_on_q && !motor_on_d) begin
      if (mode_q[2])
        motor_active_d = 1'b0;
      else
        cnt_d = CNT_W'(MOTOR_DELAY);
    end else if (!motor_on_q && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1))
        motor_active_d = 1'b0;
    end
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      phase_q        <= '0;
      motor_on_q     <= 1'b0;
      motor_active_q <= 1'b0;
      drive_sel_q    <= 1'b0;
      q6_q           <= 1'b0;
      q7_q           <= 1'b0;
      mode_q         <= '0;
      cnt_q          <= '0;
    end else begin
      phase_q        <= phase_d;
      motor_on_q     <= motor_on_d;
      motor_active_q <= motor_active_d;
      drive_sel_q    <= drive_sel_d;
      q6_q           <= q6_d;
      q7_q           <= q7_d;
      mode_q         <= mode_d;
      cnt_q          <= cnt_d;
    end
  end

  assign phase        = phase_q;
  assign motorOn      = motor_on_q;
  assign motorActive  = motor_active_q;
  assign driveSel     = drive_sel_q;
  assign q6           = q6_q;
  assign q7           = q7_q;
  assign modeReg      = mode_q;
  assign accessStrobe = fall_evt;

endmodule

// File: tb/tb_iwm_soft_switches.sv
// Directed bench for iwm_soft_switches with a short motor delay (10 cycles).
`timescale 1ns/1ps
module tb_iwm_soft_switches;

  logic       fclk = 1'b0;
  logic       reset;
  logic [3:0] addr;
  logic       devsel_n;
  logic       rw;
  logic [7:0] data;
  logic [3:0] phase;
  logic       motorOn, motorActive, driveSel, q6, q7, accessStrobe;
  logic [4:0] modeReg;

  int vectors     = 0;
  int miscompares = 0;

  iwm_soft_switches #(.MOTOR_DELAY(10), .CNT_W(24)) dut (
    .fclk(fclk), .reset(reset), .addr(addr), ._devsel(devsel_n), .rw(rw), .data(data),
    .phase(phase), .motorOn(motorOn), .motorActive(motorActive), .driveSel(driveSel),
    .q6(q6), .q7(q7), .modeReg(modeReg), .accessStrobe(accessStrobe)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One full device-select access; checks exactly one strobe cycle per access
  task automatic access(input logic [3:0] a, input logic r, input logic [7:0] d, input string tag);
    int strobes;
    strobes = 0;
    @(negedge fclk);
    addr = a; rw = r; data = d; devsel_n = 1'b0;
    repeat (6) begin
      @(negedge fclk);
      strobes += int'(accessStrobe);
    end
    devsel_n = 1'b1;
    repeat (5) @(negedge fclk);
    check({tag, "_strobe"}, strobes, 1);
  endtask

  initial begin
    int  cnt;
    bit  dropped, saw_off, seen;

    reset = 1'b1; devsel_n = 1'b1; addr = 4'h0; rw = 1'b1; data = 8'h00;
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    reset = 1'b0;
    check("reset_outs", {phase, motorOn, motorActive, driveSel, q6, q7, modeReg, accessStrobe}, 0);

    // Phases
    access(4'h1, 1'b1, 8'h00, "ph_a1"); check("phase_0001", phase, 4'b0001);
    access(4'h3, 1'b1, 8'h00, "ph_a3"); check("phase_0011", phase, 4'b0011);
    access(4'h0, 1'b1, 8'h00, "ph_a0"); check("phase_0010", phase, 4'b0010);
    access(4'hB, 1'b1, 8'h00, "drv2");  check("drive_sel1", driveSel, 1);
    access(4'hA, 1'b1, 8'h00, "drv1");  check("drive_sel0", driveSel, 0);

    // Motor on, then off with a 10-cycle hold
    access(4'h9, 1'b1, 8'h00, "mon");
    check("motor_on", motorOn, 1); check("motor_act_on", motorActive, 1);
    @(negedge fclk); addr = 4'h8; devsel_n = 1'b0; cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge fclk);
      if (i == 5) devsel_n = 1'b1;
      if (!motorOn && motorActive) cnt++;
    end
    check("delay_cycles", cnt, 10);
    check("delay_after", motorActive, 0);

    // Motor re-enabled mid-countdown: never drops, counter cleared
    access(4'h9, 1'b1, 8'h00, "mon2");
    @(negedge fclk); addr = 4'h8; devsel_n = 1'b0; dropped = 0; saw_off = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge fclk);
      if (i == 4) devsel_n = 1'b1;
      if (i == 6) begin addr = 4'h9; devsel_n = 1'b0; end
      if (i == 10) devsel_n = 1'b1;
      if (!motorOn) saw_off = 1;
      if (!motorActive) dropped = 1;
    end
    check("reon_saw_off", saw_off, 1);
    check("reon_no_drop", dropped, 0);
    check("reon_motor", motorOn, 1);
    check("reon_cnt", dut.cnt_q, 0);

    // Mode register writes
    access(4'h8, 1'b1, 8'h00, "moff");
    access(4'hD, 1'b1, 8'h00, "q6on"); check("q6_set", q6, 1);
    access(4'hF, 1'b1, 8'h00, "q7on"); check("q7_set", q7, 1);
    access(4'hF, 1'b0, 8'h1F, "mwr");  check("mode_1f", modeReg, 5'h1F);
    access(4'h9, 1'b1, 8'h00, "mon3");
    access(4'hF, 1'b0, 8'h0A, "mwr_mon"); check("mode_hold_mon", modeReg, 5'h1F);

    // Timer disabled: motorActive follows motorOn immediately
    @(negedge fclk); addr = 4'h8; devsel_n = 1'b0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fclk);
      if (i == 5) devsel_n = 1'b1;
      if (!motorOn && !seen) begin
        check("off_same_edge", motorActive, 0);
        seen = 1;
      end
    end
    check("off_seen", seen, 1);
    access(4'hE, 1'b1, 8'h00, "q7off"); check("q7_clr", q7, 0);
    access(4'hD, 1'b0, 8'h05, "mwr_q7"); check("mode_hold_q7", modeReg, 5'h1F);
    access(4'hF, 1'b1, 8'h00, "q7on2");
    access(4'hF, 1'b0, 8'h00, "mwr0");  check("mode_00", modeReg, 5'h00);

    // Reset in the middle of a countdown
    access(4'h1, 1'b1, 8'h00, "ph1");
    access(4'h7, 1'b1, 8'h00, "ph3"); check("phase_1011", phase, 4'b1011);
    access(4'h9, 1'b1, 8'h00, "mon4");
    @(negedge fclk); addr = 4'h8; devsel_n = 1'b0;
    repeat (8) @(negedge fclk);
    check("mid_cd_state", {motorOn, motorActive}, 2'b01);
    reset = 1'b1;
    @(negedge fclk);
    reset = 1'b0; devsel_n = 1'b1;
    check("rst_mid_outs", {phase, motorOn, motorActive, driveSel, q6, q7, modeReg, accessStrobe}, 0);
    check("rst_mid_cnt", dut.cnt_q, 0);
    repeat (15) @(negedge fclk);
    check("rst_stays_off", motorActive, 0);
    access(4'h9, 1'b1, 8'h00, "mon5");
    check("post_rst_on", {motorOn, motorActive}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
